// File: rtl/char_anim_ctrl.sv
// Per-character sprite sequencer: picks the animation frame at frame boundaries and
// produces the sprite-relative ROM address. Define ANIM_DEATH_EN to enable the DEAD state.
module char_anim_ctrl #(
   parameter int FRAMES_PER_STEP = 6,
   parameter int SPRITE_W        = 20,
   parameter int SPRITE_H        = 40
) (
   input  logic       vga_clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       move_left,
   input  logic       move_right,
   input  logic       airborne,
   input  logic       dead,
   input  logic [9:0] pos_x,
   input  logic [9:0] pos_y,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   output logic [2:0] sprite_sel,
   output logic       facing_left,
   output logic [9:0] rom_address,
   output logic       in_sprite
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN_R,
      S_RUN_L,
      S_AIR,
      S_DEAD
   } state_t;

   localparam logic [5:0] STEP_LAST = 6'(FRAMES_PER_STEP - 1);

   state_t     state, state_next;
   logic [5:0] step_cnt, step_cnt_next;
   logic       phase, phase_next;
   logic       facing_next;
   logic       hit;
   logic [9:0] dx, dy;

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state       <= S_IDLE;
         step_cnt    <= '0;
         phase       <= 1'b0;
         facing_left <= 1'b0;
      end else begin
         state       <= state_next;
         step_cnt    <= step_cnt_next;
         phase       <= phase_next;
         facing_left <= facing_next;
      end
   end

   // Everything animation-related moves only on frame_start so a sprite never tears mid-scan.
   always_comb begin
      state_next    = state;
      step_cnt_next = step_cnt;
      phase_next    = phase;
      facing_next   = facing_left;
      if (frame_start) begin
`ifdef ANIM_DEATH_EN
         if (state == S_DEAD || dead)
            state_next = S_DEAD;
         else
`endif
         if (airborne)
            state_next = S_AIR;
         else if (move_left && !move_right)
            state_next = S_RUN_L;
         else if (move_right && !move_left)
            state_next = S_RUN_R;
         else
            state_next = S_IDLE;

         if (state_next == S_RUN_L)
            facing_next = 1'b1;
         else if (state_next == S_RUN_R)
            facing_next = 1'b0;

         // Staying in the same run direction advances the step; any other transition restarts it.
         if ((state_next == S_RUN_R || state_next == S_RUN_L) && state_next == state) begin
            if (step_cnt == STEP_LAST) begin
               step_cnt_next = '0;
               phase_next    = ~phase;
            end else begin
               step_cnt_next = step_cnt + 6'd1;
            end
         end else begin
            step_cnt_next = '0;
            phase_next    = 1'b0;
         end
      end
   end

   always_comb begin
      sprite_sel = 3'd0;
      case (state)
         S_RUN_R: sprite_sel = 3'd1 + {2'b00, phase};
         S_RUN_L: sprite_sel = 3'd3 + {2'b00, phase};
         S_AIR:   sprite_sel = 3'd5 + {2'b00, facing_left};
`ifdef ANIM_DEATH_EN
         S_DEAD:  sprite_sel = 3'd7;
`else
         S_DEAD:  sprite_sel = 3'd0;
`endif
         default: sprite_sel = 3'd0;
      endcase
   end

`ifndef ANIM_DEATH_EN
   logic unused_dead;
   assign unused_dead = dead;
`endif

   // Box test is done at 11 bits so a sprite hanging off the right/bottom edge does not wrap.
   always_comb begin
      hit = ({1'b0, DrawX} >= {1'b0, pos_x}) &&
            ({1'b0, DrawX} <  {1'b0, pos_x} + 11'(SPRITE_W)) &&
            ({1'b0, DrawY} >= {1'b0, pos_y}) &&
            ({1'b0, DrawY} <  {1'b0, pos_y} + 11'(SPRITE_H));
      dx  = DrawX - pos_x;
      dy  = DrawY - pos_y;
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         in_sprite   <= 1'b0;
         rom_address <= '0;
      end else begin
         in_sprite   <= hit;
         rom_address <= hit ? (dx + dy * 10'(SPRITE_W)) : 10'd0;
      end
   end

endmodule

// File: tb/tb_char_anim_ctrl.sv
// Directed, scoreboard-driven bench for char_anim_ctrl at default parameters;
// expectations for the death feature follow ANIM_DEATH_EN as compiled.
module tb_char_anim_ctrl;

   localparam int FPS = 6;
   localparam int SW  = 20;
   localparam int SH  = 40;

   logic       vga_clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_start = 1'b0;
   logic       move_left = 1'b0;
   logic       move_right = 1'b0;
   logic       airborne = 1'b0;
   logic       dead = 1'b0;
   logic [9:0] pos_x = 10'd500;
   logic [9:0] pos_y = 10'd400;
   logic [9:0] DrawX = 10'd0;
   logic [9:0] DrawY = 10'd0;
   logic [2:0] sprite_sel;
   logic       facing_left;
   logic [9:0] rom_address;
   logic       in_sprite;

   char_anim_ctrl #(.FRAMES_PER_STEP(FPS), .SPRITE_W(SW), .SPRITE_H(SH)) dut (
      .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start),
      .move_left(move_left), .move_right(move_right), .airborne(airborne), .dead(dead),
      .pos_x(pos_x), .pos_y(pos_y), .DrawX(DrawX), .DrawY(DrawY),
      .sprite_sel(sprite_sel), .facing_left(facing_left),
      .rom_address(rom_address), .in_sprite(in_sprite)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct {
      string       tag;
      int          sig;
      logic [10:0] expVal;
   } exp_t;

   exp_t expQ[$];
   int   checkCount = 0;
   int   passCount  = 0;
   int   failCount  = 0;

   // sig: 0 sprite_sel, 1 facing_left, 2 in_sprite, 3 rom_address
   task automatic pushExp(input string tag, input int sig, input int value);
      exp_t e;
      e.tag    = tag;
      e.sig    = sig;
      e.expVal = 11'(value);
      expQ.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t        e;
      logic [10:0] obs;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         case (e.sig)
            0:       obs = {8'd0, sprite_sel};
            1:       obs = {10'd0, facing_left};
            2:       obs = {10'd0, in_sprite};
            default: obs = {1'b0, rom_address};
         endcase
         checkCount++;
         assert (obs === e.expVal) passCount++;
         else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", e.tag, obs, e.expVal);
         end
      end
   endtask

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   // One frame_start pulse, then a few ordinary scan cycles.
   task automatic applyStimulus();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      tick();
   endtask

   function automatic int modelAddr(input int px, input int py, input int x, input int y,
                                    output bit isHit);
      isHit = (x >= px) && (x < px + SW) && (y >= py) && (y < py + SH);
      return isHit ? (x - px) + (y - py) * SW : 0;
   endfunction

   task automatic addrCase(input string tag, input int px, input int py, input int x, input int y);
      bit h;
      int a;
      pos_x = 10'(px);
      pos_y = 10'(py);
      DrawX = 10'(x);
      DrawY = 10'(y);
      a = modelAddr(px, py, x, y, h);
      pushExp({tag, "_in"}, 2, int'(h));
      pushExp({tag, "_addr"}, 3, a);
      tick();
      checkOutput();
   endtask

   initial begin
      bit deathEn;
`ifdef ANIM_DEATH_EN
      deathEn = 1'b1;
`else
      deathEn = 1'b0;
`endif
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      pushExp("rst_sel", 0, 0);
      pushExp("rst_face", 1, 0);
      pushExp("rst_in", 2, 0);
      pushExp("rst_addr", 3, 0);
      checkOutput();

      for (int i = 0; i < 3; i++) begin
         pushExp("idle_sel", 0, 0);
         applyStimulus();
         checkOutput();
      end

      move_right = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         pushExp($sformatf("runR_f%0d", i), 0, (((i - 1) / FPS) % 2 == 1) ? 2 : 1);
         pushExp("runR_face", 1, 0);
         applyStimulus();
         checkOutput();
      end
      for (int i = 14; i <= 19; i++) applyStimulus();
      pushExp("runR_phase1", 0, 2);
      checkOutput();

      move_right = 1'b0;
      move_left  = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         pushExp($sformatf("runL_f%0d", i), 0, (i == 7) ? 4 : 3);
         pushExp("runL_face", 1, 1);
         applyStimulus();
         checkOutput();
      end

      airborne = 1'b1;
      pushExp("air_left", 0, 6);
      applyStimulus();
      checkOutput();

      airborne   = 1'b0;
      move_right = 1'b1;
      pushExp("both_sel", 0, 0);
      pushExp("both_face", 1, 1);
      applyStimulus();
      checkOutput();

      move_left = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pushExp("noframe_sel", 0, 0);
         tick();
         checkOutput();
      end
      airborne = 1'b1;
      pushExp("noframe_air", 0, 0);
      tick();
      checkOutput();
      airborne = 1'b0;

      addrCase("addr_basic", 100, 50, 105, 52);
      addrCase("addr_last", 100, 50, 119, 89);
      addrCase("addr_right", 100, 50, 120, 50);
      addrCase("addr_left", 100, 50, 99, 50);
      addrCase("addr_below", 100, 50, 100, 90);
      addrCase("addr_first", 100, 50, 100, 50);
      addrCase("addr_nowrap", 1015, 0, 1023, 0);
      addrCase("addr_wrapx", 1015, 0, 2, 0);

      dead = 1'b1;
      pushExp("dead_f0", 0, deathEn ? 7 : 1);
      applyStimulus();
      checkOutput();
      dead = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         pushExp("dead_hold", 0, deathEn ? 7 : 1);
         applyStimulus();
         checkOutput();
      end
      move_right = 1'b0;
      move_left  = 1'b1;
      pushExp("dead_left", 0, deathEn ? 7 : 3);
      applyStimulus();
      checkOutput();

      pos_x       = 10'd100;
      pos_y       = 10'd50;
      DrawX       = 10'd110;
      DrawY       = 10'd60;
      reset       = 1'b1;
      frame_start = 1'b1;
      tick();
      reset       = 1'b0;
      frame_start = 1'b0;
      pushExp("rst2_sel", 0, 0);
      pushExp("rst2_face", 1, 0);
      pushExp("rst2_in", 2, 0);
      pushExp("rst2_addr", 3, 0);
      checkOutput();

      pushExp("post_rst_runL", 0, 3);
      applyStimulus();
      checkOutput();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/char_anim_ctrl.md
# char_anim_ctrl

Per-character sprite sequencer that selects the animation frame ROM (idle, run phases, jump, death) and generates the pixel-relative ROM address and in-sprite flag for a 20×40 character sprite. It sits between the player-movement logic and the per-frame sprite ROM/palette instances in the renderer. Frame selection updates only at frame boundaries, so a sprite never tears mid-scan. One instance per character (Fireboy, Watergirl).

## Interface
Parameters:
- FRAMES_PER_STEP, 6: video frames per run-animation phase; legal range 1–63.
- SPRITE_W, 20: sprite width in pixels.
- SPRITE_H, 40: sprite height in pixels; SPRITE_W*SPRITE_H ≤ 1024.

Ports:
- vga_clk  in  1  pixel clock; single clock domain.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse per video frame (start of vertical blank).
- move_left, move_right  in  1 each  held movement intent, sampled on frame_start only.
- airborne  in  1  character not on ground, sampled on frame_start.
- dead  in  1  death event, sampled on frame_start.
- pos_x, pos_y  in  10 each  sprite top-left screen coordinate.
- DrawX, DrawY  in  10 each  current scan coordinate.
- sprite_sel  out  3  0 IDLE, 1 RIGHT1, 2 RIGHT2, 3 LEFT1, 4 LEFT2, 5 JUMP_R, 6 JUMP_L, 7 DEATH.
- facing_left  out  1  last horizontal run direction.
- rom_address  out  10  sprite-relative ROM address.
- in_sprite  out  1  current pixel is inside the sprite box.

## Operation
- States: IDLE, RUN_R, RUN_L, AIR, DEAD. Transitions occur only on cycles where frame_start=1.
- Next-state priority at frame_start: dead → DEAD; else airborne → AIR; else exactly one of move_left/move_right → RUN_L/RUN_R; else IDLE (covers both asserted and neither).
- DEAD is absorbing; only reset leaves it.
- facing_left: set on entry to RUN_L, cleared on entry to RUN_R, otherwise held.
- Step counter (6 bits) and phase bit: in RUN_x, each frame_start with the state unchanged increments the counter; at FRAMES_PER_STEP-1 the counter wraps to 0 and phase toggles. Entering RUN_x from any other state, including the opposite RUN, zeroes both counter and phase. Outside RUN, counter and phase are held at 0.
- sprite_sel mapping: IDLE→0; RUN_R→1+phase; RUN_L→3+phase; AIR→5+facing_left; DEAD→7.
- Address path, compared at 11 bits so pos_x+SPRITE_W > 1023 does not wrap: hit = DrawX≥pos_x && DrawX<pos_x+SPRITE_W && DrawY≥pos_y && DrawY<pos_y+SPRITE_H.
- Registered each cycle: in_sprite ← hit; rom_address ← hit ? (DrawX-pos_x) + (DrawY-pos_y)*SPRITE_W : 0.

## Timing
- Reset values: state IDLE, sprite_sel 0, facing_left 0, counter 0, phase 0, rom_address 0, in_sprite 0.
- Reset asserted mid-frame clears everything on the next edge; reset has priority over frame_start in the same cycle.
- sprite_sel and facing_left change only on the edge after frame_start, and are stable for the rest of the frame.
- rom_address and in_sprite have 1-cycle latency from DrawX/DrawY/pos_x/pos_y. The downstream ROM, clocked on the negedge, returns data in time for the renderer's next posedge register.
- Address is at most SPRITE_W*SPRITE_H-1 (799 at defaults).

## Configuration
- ANIM_DEATH_EN defined: DEAD state and sprite_sel=7 are present, as described above.
- ANIM_DEATH_EN undefined: the dead input is ignored, DEAD is never entered, and sprite_sel never equals 7. All other behaviour is identical.

## Test plan
- Reset, then 3 frame_start pulses with no inputs → sprite_sel=0, facing_left=0, in_sprite=0, rom_address=0.
- move_right held for 13 frame_start pulses (FRAMES_PER_STEP=6) → sprite_sel 1 for frames 1–6, 2 for frames 7–12, 1 at frame 13.
- RUN_R at phase 1, then move_left asserted → next frame sprite_sel=3, facing_left=1, counter restarted. Then airborne asserted → sprite_sel=6.
- Both move inputs high → sprite_sel=0. Inputs toggled between frame_start pulses → no output change.
- pos=(100,50), DrawX=105, DrawY=52 → one cycle later in_sprite=1, rom_address=45. With pos_x=1015, DrawX=1023 → in_sprite=1, no wrap.
- dead pulse at frame_start, then reset → with ANIM_DEATH_EN, sprite_sel=7 held across frames with moves asserted; reset returns 0. Without the macro, sprite_sel follows moves.
